// File: rtl/ni_flit_scheduler.sv
// Network-interface transmit scheduler: round-robin packet arbitration between
// NREQ sources, then flit-by-flit sequencing with backpressure and grant hold.
module ni_flit_scheduler #(
   parameter int          NREQ     = 2,
   parameter int          CNTW     = 4,
   parameter int          FTYPEWD  = 2,
   parameter logic [FTYPEWD-1:0] ENC_PAYL = 2'd0,
   parameter logic [FTYPEWD-1:0] ENC_HEAD = 2'd1,
   parameter logic [FTYPEWD-1:0] ENC_TAIL = 2'd2,
   parameter logic [FTYPEWD-1:0] ENC_SING = 2'd3,
   localparam int         SELW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      src_req,
   input  logic [NREQ*CNTW-1:0] src_len,
   input  logic                 link_stall,
   output logic [NREQ-1:0]      src_grant,
   output logic [SELW-1:0]      src_sel,
   output logic                 flit_valid,
   output logic [CNTW-1:0]      flit_counter,
   output logic [FTYPEWD-1:0]   flit_type,
   output logic                 pkt_done
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state;
   logic [SELW-1:0] rr_ptr;
   logic [CNTW-1:0] len_q;

   logic            last_flit;
   logic            accept;
   logic [SELW-1:0] next_ptr;
   logic [SELW-1:0] arb_base;
   logic [NREQ-1:0] arb_mask;
   logic            arb_found;
   logic [SELW-1:0] arb_idx;
   logic [NREQ-1:0] arb_onehot;
   logic [CNTW-1:0] arb_len;

   assign last_flit = (flit_counter == len_q - 1'b1);
   assign accept    = flit_valid && !link_stall;
   assign pkt_done  = accept && last_flit;
   assign next_ptr  = (src_sel == SELW'(NREQ - 1)) ? '0 : src_sel + 1'b1;

   // Idle search starts at the RR pointer; the back-to-back search starts just
   // past the finishing source and masks it out, which is the same rotation.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_mask  = src_req;
      arb_base  = rr_ptr;
      if (state == SEND) begin
         arb_base          = next_ptr;
         arb_mask[src_sel] = 1'b0;
      end
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = int'(arb_base) + k;
         if (c >= NREQ) c = c - NREQ;
         if (!arb_found && arb_mask[c]) begin
            arb_found = 1'b1;
            arb_idx   = c[SELW-1:0];
         end
      end
      arb_onehot = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
      arb_len    = src_len[int'(arb_idx)*CNTW +: CNTW];
      if (arb_len == '0) arb_len = CNTW'(1);
   end

   always_comb begin
      flit_type = '0;
      if (flit_valid) begin
         if (len_q == CNTW'(1))        flit_type = ENC_SING;
         else if (flit_counter == '0)  flit_type = ENC_HEAD;
         else if (last_flit)           flit_type = ENC_TAIL;
         else                          flit_type = ENC_PAYL;
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so all of them update together.
      if (!reset_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         len_q        <= '0;
         src_grant    <= '0;
         src_sel      <= '0;
         flit_valid   <= 1'b0;
         flit_counter <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  state        <= SEND;
                  src_grant    <= arb_onehot;
                  src_sel      <= arb_idx;
                  len_q        <= arb_len;
                  flit_valid   <= 1'b1;
                  flit_counter <= '0;
               end
            end
            SEND: begin
               if (accept) begin
                  if (last_flit) begin
                     rr_ptr       <= next_ptr;
                     flit_counter <= '0;
                     if (arb_found) begin
                        src_grant <= arb_onehot;
                        src_sel   <= arb_idx;
                        len_q     <= arb_len;
                     end else begin
                        state      <= IDLE;
                        src_grant  <= '0;
                        src_sel    <= '0;
                        flit_valid <= 1'b0;
                     end
                  end else begin
                     flit_counter <= flit_counter + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ni_flit_scheduler.sv
// Directed bench for ni_flit_scheduler: single, multi-flit, stalled, alternating,
// mid-packet reset and zero-length packets, checked by immediate assertions.
module tb_ni_flit_scheduler;

   localparam int NREQ = 2;
   localparam int CNTW = 4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   src_req;
   logic [NREQ*CNTW-1:0] src_len;
   logic              link_stall;
   logic [NREQ-1:0]   src_grant;
   logic [0:0]        src_sel;
   logic              flit_valid;
   logic [CNTW-1:0]   flit_counter;
   logic [1:0]        flit_type;
   logic              pkt_done;

   int checks = 0;
   int errors = 0;

   ni_flit_scheduler #(.NREQ(NREQ), .CNTW(CNTW)) dut (
      .clock(clock), .reset_n(reset_n), .src_req(src_req), .src_len(src_len),
      .link_stall(link_stall), .src_grant(src_grant), .src_sel(src_sel),
      .flit_valid(flit_valid), .flit_counter(flit_counter), .flit_type(flit_type),
      .pkt_done(pkt_done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic check_flit(input string tag, input int sel, input int cnt,
                             input int typ, input int done);
      check({tag, ".valid"}, 32'(flit_valid), 32'd1);
      check({tag, ".sel"}, 32'(src_sel), 32'(sel));
      check({tag, ".grant"}, 32'(src_grant), 32'(1 << sel));
      check({tag, ".cnt"}, 32'(flit_counter), 32'(cnt));
      check({tag, ".type"}, 32'(flit_type), 32'(typ));
      check({tag, ".done"}, 32'(pkt_done), 32'(done));
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 32'(flit_valid), 32'd0);
      check({tag, ".grant"}, 32'(src_grant), 32'd0);
      check({tag, ".sel"}, 32'(src_sel), 32'd0);
      check({tag, ".cnt"}, 32'(flit_counter), 32'd0);
      check({tag, ".type"}, 32'(flit_type), 32'd0);
      check({tag, ".done"}, 32'(pkt_done), 32'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      src_req    = '0;
      src_len    = '0;
      link_stall = 1'b0;
      step();
      step();
      check_idle("reset");
      reset_n = 1'b1;
      step();
      check_idle("idle_no_req");

      // Single-flit packet from source 0; rr pointer moves to 1.
      src_req = 2'b01;
      src_len[0 +: CNTW] = 4'd1;
      step();
      check_flit("sing", 0, 0, 3, 1);
      src_req = 2'b00;
      step();
      check_idle("sing_after");

      // Source 1, four flits; len change mid-packet must be ignored.
      src_req = 2'b10;
      src_len[CNTW +: CNTW] = 4'd4;
      step();
      check_flit("len4_f0", 1, 0, 1, 0);
      src_len[CNTW +: CNTW] = 4'd7;
      step();
      check_flit("len4_f1", 1, 1, 0, 0);
      step();
      check_flit("len4_f2", 1, 2, 0, 0);
      step();
      check_flit("len4_f3", 1, 3, 2, 1);
      src_req = 2'b00;
      step();
      check_idle("len4_after");

      // Source 0, three flits, stall three cycles on the second flit and once on the tail.
      src_req = 2'b01;
      src_len[0 +: CNTW] = 4'd3;
      step();
      check_flit("st_f0", 0, 0, 1, 0);
      step();
      check_flit("st_f1a", 0, 1, 0, 0);
      link_stall = 1'b1;
      step();
      check_flit("st_f1b", 0, 1, 0, 0);
      step();
      check_flit("st_f1c", 0, 1, 0, 0);
      step();
      check_flit("st_f1d", 0, 1, 0, 0);
      link_stall = 1'b0;
      step();
      check_flit("st_f2", 0, 2, 2, 1);
      link_stall = 1'b1;
      #1;
      check("st_tail_stalled.done", 32'(pkt_done), 32'd0);
      step();
      check_flit("st_f2_held", 0, 2, 2, 0);
      link_stall = 1'b0;
      #1;
      check("st_tail_accept.done", 32'(pkt_done), 32'd1);
      src_req = 2'b00;
      step();
      check_idle("st_after");

      // Both sources, len 2: rr pointer is 1, so grants go 1,0,1,0 back-to-back.
      src_req = 2'b11;
      src_len[0 +: CNTW] = 4'd2;
      src_len[CNTW +: CNTW] = 4'd2;
      step();
      for (int p = 0; p < 4; p++) begin
         for (int f = 0; f < 2; f++) begin
            check_flit($sformatf("rr_p%0d_f%0d", p, f), (p % 2 == 0) ? 1 : 0, f,
                       (f == 0) ? 1 : 2, f);
            if (p == 3 && f == 1) src_req = 2'b00;
            step();
         end
      end
      check_idle("rr_after");

      // Reset in the middle of a five-flit packet from source 0.
      src_req = 2'b01;
      src_len[0 +: CNTW] = 4'd5;
      step();
      check_flit("rst_f0", 0, 0, 1, 0);
      step();
      check_flit("rst_f1", 0, 1, 0, 0);
      step();
      check_flit("rst_f2", 0, 2, 0, 0);
      reset_n = 1'b0;
      step();
      check_idle("rst_mid");
      reset_n = 1'b1;
      step();
      for (int f = 0; f < 5; f++) begin
         check_flit($sformatf("rst_re_f%0d", f), 0, f,
                    (f == 0) ? 1 : ((f == 4) ? 2 : 0), (f == 4) ? 1 : 0);
         if (f == 4) src_req = 2'b00;
         step();
      end
      check_idle("rst_re_after");

      // Zero length on source 1 behaves as a single flit.
      src_req = 2'b10;
      src_len[CNTW +: CNTW] = 4'd0;
      step();
      check_flit("len0", 1, 0, 3, 1);
      src_req = 2'b00;
      step();
      check_idle("len0_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ni_flit_scheduler.md
Name: ni_flit_scheduler

Overview:
- Network-interface transmit scheduler.
- Arbitrates round-robin between NREQ packet sources (e.g. request and response paths) that each hold a ready-to-send packet.
- Sequences the granted packet flit by flit and produces the flit counter, flit type and source select that drive the NI output mux toward the switch.
- Honours link backpressure, and holds the grant for the whole packet so flits of different packets never interleave.

Parameters:
- NREQ, 2, number of packet sources (2..8)
- CNTW, 4, flit counter / packet length width
- FTYPEWD, 2, flit type width
- ENC_PAYL, 2'd0, payload flit encoding
- ENC_HEAD, 2'd1, head flit encoding
- ENC_TAIL, 2'd2, tail flit encoding
- ENC_SING, 2'd3, single-flit packet encoding

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- src_req  in  NREQ  source i has a complete packet ready; must stay high until its pkt_done
- src_len  in  NREQ*CNTW  flit count of source i's packet, slice [i*CNTW +: CNTW]
- link_stall  in  1  switch cannot accept a flit this cycle
- src_grant  out  NREQ  one-hot, source owning the link; held for the whole packet
- src_sel  out  clog2(NREQ) (min 1)  binary index of the granted source, drives the data mux
- flit_valid  out  1  flit presented on the link this cycle
- flit_counter  out  CNTW  index of the current flit within its packet (0-based)
- flit_type  out  FTYPEWD  type of the current flit
- pkt_done  out  1  one-cycle pulse when the tail/single flit is accepted (flit_valid & !link_stall)

Behaviour:
- Reset (reset_n low at a clock edge) forces all outputs to 0, state IDLE and the RR pointer to 0. This applies even mid-packet: the partial packet is abandoned with no tail, and the source must re-request.
- State IDLE:
  - If any src_req is set, pick the first requester at or after the RR pointer, cyclically.
  - Latch its index and len_q = src_len slice. Length 0 is latched as 1.
  - Move to SEND next cycle.
  - src_grant/src_sel update on that same edge.
  - flit_counter = 0.
- State SEND:
  - flit_valid = 1.
  - flit_type is combinational from flit_counter and len_q:
    - len_q == 1 -> ENC_SING
    - counter == 0 -> ENC_HEAD
    - counter == len_q-1 -> ENC_TAIL
    - else ENC_PAYL
  - link_stall = 1: counter, type and grant are held unchanged.
  - Accepted non-last flit: counter increments.
  - Accepted last flit:
    - pkt_done pulses.
    - RR pointer = granted index + 1, wrapping at NREQ.
    - Counter clears.
    - Next winner: if another src_req (excluding the just-finished source) is pending, grant it directly in SEND with no idle cycle (back-to-back). Otherwise return to IDLE, with src_grant = 0 and flit_valid = 0.
- Latency: src_req rising while idle -> first flit_valid on the next cycle (1 cycle).
- len_q is frozen for the packet; src_len changes during SEND are ignored.
- src_req dropping for the granted source mid-packet is a protocol error: it is ignored and the packet completes.
- Maximum packet length is 2^CNTW-1 flits, so the counter never wraps within a packet.
- Fairness: every requesting source is granted within NREQ packets.

Test Plan:
- Single source, len=1: src_req[0]=1 -> next cycle flit_valid=1, flit_type=3 (SING), counter=0; pkt_done same cycle; IDLE after if req drops.
- Source 1, len=4, no stall -> types 1,0,0,2 on consecutive cycles; counters 0..3; src_sel=1; one pkt_done on the tail.
- Len=3 with link_stall high on the 2nd flit for 3 cycles -> flit held at counter=1 type=0 for 4 cycles total; then tail; no skipped or duplicated counter.
- Both sources continuously requesting, len=2 each -> grants alternate 0,1,0,1 with no idle cycle between packets; flits never interleave.
- reset_n low during flit 2 of a 5-flit packet -> next cycle all outputs 0, IDLE; after release, the same source restarts at counter=0 with HEAD.
- src_len=0 -> treated as 1: single SING flit, pkt_done asserted.
